// File: rtl/rs_arb_pkg.sv
// Shared types and constants for the RS(15,9) codec arbiter: symbol geometry,
// the response FIFO entry and the in-flight tag that follows a job through the codec.
package rs_arb_pkg;
    localparam int K      = 9;
    localparam int N      = 15;
    localparam int SYM_W  = 4;
    localparam int DATA_W = K * SYM_W;
    localparam int CHK_W  = (N - K) * SYM_W;
    // Wide enough for the largest supported requester count (4).
    localparam int ID_W   = 2;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              gen;
        logic [DATA_W-1:0] data;
        logic [CHK_W-1:0]  chk;
        logic              err_detect;
        logic              err_multpl;
    } rsp_entry_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            gen;
    } tag_t;
endpackage

// File: rtl/rs_arb_rsp_fifo.sv
// Show-ahead synchronous response FIFO; the head entry is visible on rd_data
// whenever rd_valid is high and leaves on rd_en.
module rs_arb_rsp_fifo
    import rs_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  rsp_entry_t wr_data,
    input  logic       rd_en,
    output logic       rd_valid,
    output rsp_entry_t rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    rsp_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            do_rd;

    assign full     = (count == CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign do_rd    = rd_en && rd_valid;

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            if ((wr_en && !full) && !do_rd) begin
                count <= count + CW'(1);
            end else if (do_rd && !(wr_en && !full)) begin
                count <= count - CW'(1);
            end
        end
    end

    // Credit accounting upstream makes a write into a full FIFO impossible.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(wr_en && full)) else $error("rs_arb_rsp_fifo: write while full");
        end
    end
endmodule

// File: rtl/rs_codec_arb.sv
// Round-robin arbiter sharing one RS(15,9) codec between requesters, with tag
// tracking through the codec latency and a credit-guarded response FIFO.
// Optional RS_ARB_STATS_EN adds stat_corr / stat_uncorr decode error counters.
module rs_codec_arb #(
    parameter int NUM_REQ   = 2,
    parameter int CODEC_LAT = 1,
    parameter int RSP_DEPTH = 4,
    parameter int SYM_W     = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  correct_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0]                    req_gen,
    input  logic [NUM_REQ*rs_arb_pkg::DATA_W-1:0] req_data,
    input  logic [NUM_REQ*rs_arb_pkg::CHK_W-1:0]  req_chk,
    output logic                                  cdc_gen,
    output logic                                  cdc_correct_n,
    output logic [rs_arb_pkg::DATA_W-1:0]         cdc_datain,
    output logic [rs_arb_pkg::CHK_W-1:0]          cdc_chkin,
    input  logic [rs_arb_pkg::DATA_W-1:0]         cdc_dataout,
    input  logic [rs_arb_pkg::CHK_W-1:0]          cdc_chkout,
    input  logic                                  cdc_err_detect,
    input  logic                                  cdc_err_multpl,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [((NUM_REQ > 2) ? 1 : 0):0]      rsp_id,
    output logic                                  rsp_gen,
    output logic [rs_arb_pkg::DATA_W-1:0]         rsp_data,
    output logic [rs_arb_pkg::CHK_W-1:0]          rsp_chk,
    output logic                                  rsp_err_detect,
    output logic                                  rsp_err_multpl
`ifdef RS_ARB_STATS_EN
    ,
    output logic [15:0]                           stat_corr,
    output logic [15:0]                           stat_uncorr
`endif
);
    import rs_arb_pkg::*;

    localparam int RID_W = (NUM_REQ > 2) ? 2 : 1;
    localparam int CR_W  = $clog2(RSP_DEPTH + 1);

    if (SYM_W != rs_arb_pkg::SYM_W || NUM_REQ < 2 || NUM_REQ > 4 ||
        CODEC_LAT < 1 || RSP_DEPTH < 1) begin : g_param_check
        $error("rs_codec_arb: unsupported parameter set");
    end

    logic [NUM_REQ-1:0] grant;
    logic [RID_W-1:0]   gnt_idx;
    logic [RID_W-1:0]   ptr;
    logic [CR_W-1:0]    credits;
    logic               accept;
    logic               pop;
    int                 cand;
    tag_t               issue_tag;
    tag_t               tag_pipe [CODEC_LAT];
    tag_t               cap_tag;
    rsp_entry_t         wr_entry;
    rsp_entry_t         head;
    logic               fifo_valid;
    logic               unused_id_bits;

    // Scan downwards so the lowest offset from ptr+1 is the one that sticks.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        cand    = 0;
        if (credits != '0) begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                cand = (int'(ptr) + k) % NUM_REQ;
                if (req_valid[cand]) begin
                    grant       = '0;
                    grant[cand] = 1'b1;
                    gnt_idx     = RID_W'(cand);
                end
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign pop       = fifo_valid && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= RID_W'(NUM_REQ - 1);
            credits       <= CR_W'(RSP_DEPTH);
            cdc_gen       <= 1'b0;
            cdc_correct_n <= 1'b0;
            cdc_datain    <= '0;
            cdc_chkin     <= '0;
            issue_tag     <= '0;
        end else begin
            issue_tag <= '0;
            if (accept) begin
                ptr             <= gnt_idx;
                cdc_gen         <= req_gen[gnt_idx];
                cdc_correct_n   <= correct_n;
                cdc_datain      <= req_data[int'(gnt_idx)*DATA_W +: DATA_W];
                cdc_chkin       <= req_chk[int'(gnt_idx)*CHK_W +: CHK_W];
                issue_tag.valid <= 1'b1;
                issue_tag.id    <= ID_W'(gnt_idx);
                issue_tag.gen   <= req_gen[gnt_idx];
            end
            if (accept && !pop) begin
                credits <= credits - CR_W'(1);
            end else if (pop && !accept) begin
                credits <= credits + CR_W'(1);
            end
        end
    end

    // issue_tag lines up with the codec input registers; the pipe adds the codec latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CODEC_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < CODEC_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign cap_tag = tag_pipe[CODEC_LAT-1];

    always_comb begin
        wr_entry            = '0;
        wr_entry.id         = cap_tag.id;
        wr_entry.gen        = cap_tag.gen;
        wr_entry.data       = cdc_dataout;
        wr_entry.chk        = cdc_chkout;
        wr_entry.err_detect = cdc_err_detect && !cap_tag.gen;
        wr_entry.err_multpl = cdc_err_multpl && !cap_tag.gen;
    end

    rs_arb_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cap_tag.valid),
        .wr_data  (wr_entry),
        .rd_en    (pop),
        .rd_valid (fifo_valid),
        .rd_data  (head)
    );

    assign rsp_valid      = fifo_valid;
    assign rsp_id         = fifo_valid ? head.id[RID_W-1:0] : '0;
    assign rsp_gen        = fifo_valid ? head.gen : 1'b0;
    assign rsp_data       = fifo_valid ? head.data : '0;
    assign rsp_chk        = fifo_valid ? head.chk : '0;
    assign rsp_err_detect = fifo_valid ? head.err_detect : 1'b0;
    assign rsp_err_multpl = fifo_valid ? head.err_multpl : 1'b0;
    assign unused_id_bits = ^head.id;

`ifdef RS_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_corr   <= '0;
            stat_uncorr <= '0;
        end else if (pop && !head.gen) begin
            if (head.err_multpl) begin
                if (stat_uncorr != 16'hFFFF) stat_uncorr <= stat_uncorr + 16'd1;
            end else if (head.err_detect) begin
                if (stat_corr != 16'hFFFF) stat_corr <= stat_corr + 16'd1;
            end
        end
    end
`endif
endmodule

// File: doc/rs_codec_arb.md
Name: rs_codec_arb

Overview:
Round-robin arbiter and sequencer that shares one RS(15,9) GF(16) codec core between NUM_REQ requesters. Each requester submits an encode or decode job over a valid/ready handshake. The block issues at most one job per cycle to the codec and tracks the job's owner through the codec's fixed latency. Results are buffered in a credit-controlled response FIFO, so the codec never needs backpressure.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
CODEC_LAT, 1, fixed codec latency in cycles, from inputs sampled to outputs valid (>=1)
RSP_DEPTH, 4, response FIFO depth (>=1); also the maximum number of jobs in flight plus buffered
SYM_W, 4, symbol width in bits (GF(16))

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
correct_n  in  1  global setting: 0 = codec corrects errors on decode jobs
req_valid  in  NUM_REQ  per-requester job valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_gen  in  NUM_REQ  per-requester job type: 1 = encode, 0 = decode
req_data  in  NUM_REQ*36  9 data symbols per requester
req_chk  in  NUM_REQ*24  6 check symbols per requester (decode only)
cdc_gen  out  1  codec mode
cdc_correct_n  out  1  codec correct enable
cdc_datain  out  36  codec data input
cdc_chkin  out  24  codec check input
cdc_dataout  in  36  codec data result
cdc_chkout  in  24  codec check/syndrome result
cdc_err_detect  in  1  codec error detected
cdc_err_multpl  in  1  codec uncorrectable error
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer accept
rsp_id  out  $clog2(NUM_REQ)  owner of the response (minimum 1 bit)
rsp_gen  out  1  job type echo
rsp_data  out  36  result data
rsp_chk  out  24  result check symbols
rsp_err_detect  out  1  error flag (forced 0 for encode jobs)
rsp_err_multpl  out  1  uncorrectable flag (forced 0 for encode jobs)

Behaviour:
- Reset (async, rst=1). All cdc_* outputs go to 0. rsp_valid=0 and rsp_* = 0. credits=RSP_DEPTH. Tag pipe is cleared. RR pointer=NUM_REQ-1, so requester 0 has first priority. In-flight jobs and FIFO contents are discarded.
- Grant (combinational):
  - Only when credits>0.
  - Search starts at pointer+1 with wrap-around; the first requester with req_valid set is granted.
  - req_ready[i]=grant[i]; ready is never asserted without valid.
  - The pointer updates to the granted index on acceptance only.
- Issue:
  - On the acceptance edge, the cdc_* registers load the granted job. cdc_correct_n is sampled from correct_n at that edge.
  - Tag {valid=1, id, gen} enters the tag shift register, depth CODEC_LAT.
  - With no acceptance, cdc_* hold their previous values and a tag with valid=0 is shifted in.
- Capture: when the tag pipe's output valid=1, the codec outputs plus id/gen are written into the FIFO on that edge.
- Latency: rsp_valid rises CODEC_LAT+1 edges after the acceptance edge, assuming an empty FIFO. Default is 2.
- Response FIFO:
  - Show-ahead: rsp_* reflect the head entry while rsp_valid=1.
  - Pop on rsp_valid&rsp_ready.
  - rsp_* are stable while rsp_valid=1 and rsp_ready=0.
- Credits:
  - -1 on acceptance, +1 on pop; unchanged when both occur in the same cycle.
  - Range 0..RSP_DEPTH.
  - FIFO overflow is impossible by construction; a simulation assertion fires on a write when full.
- Simultaneous requests: round-robin gives strict alternation under continuous valid with free credits, i.e. full throughput of one job per cycle.
- Reset mid-operation: all tags in flight are dropped; no stale response appears after reset is released.

Optional Feature:
Macro RS_ARB_STATS_EN.
- When defined, adds output ports:
  - stat_corr (16): count of decode responses with err_detect=1 and err_multpl=0.
  - stat_uncorr (16): count of decode responses with err_multpl=1.
- Counters increment on FIFO pop, saturate at 16'hFFFF, and clear on rst.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package rs_arb_pkg:
  - Constants K=9, N=15, SYM_W=4, DATA_W=36, CHK_W=24.
  - Packed struct rsp_entry_t {id, gen, data, chk, err_detect, err_multpl}.
  - Packed struct tag_t {valid, id, gen}.
- Sub-module rs_arb_rsp_fifo: parameterised synchronous FIFO (depth RSP_DEPTH, payload rsp_entry_t, show-ahead, async active-high reset).

Test Plan:
- Reset check: rst pulse -> all req_ready=0 while valid=0; rsp_valid=0; cdc_datain=0; credits=4.
- Single encode, requester 0 (CODEC_LAT=1): datain=36'h123456789 accepted at edge E0 -> cdc_datain=36'h123456789 after E0; rsp_valid after E2 with rsp_id=0, rsp_gen=1, err flags=0.
- Fairness: both requesters hold valid continuously, rsp_ready=1 -> acceptance order 0,1,0,1,... over 8 jobs; rsp_id sequence matches.
- Backpressure: rsp_ready=0, requester 1 continuously valid -> exactly 4 acceptances, then req_ready=0. A single pop -> exactly one further acceptance.
- Decode error: codec model returns err_detect=1, err_multpl=1 for a job from requester 1 -> rsp_err_multpl=1, rsp_id=1. With RS_ARB_STATS_EN, stat_uncorr=1 and stat_corr=0.
- Reset mid-flight: 3 jobs accepted, then rst asserted for 1 cycle -> after release rsp_valid stays 0 for 10 cycles with no requests; credits=4.
